// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: FSM encoding and
// default bus widths.
package imem_fetch_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_if.sv
// Instruction memory read port. Signal names follow the fetch block's
// point of view (o_ driven by the fetch unit, i_ driven by the memory).
interface imem_fetch_if
    import imem_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  o_mem_req;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic                  i_mem_gnt;
    logic                  i_mem_rvalid;
    logic [DATA_WIDTH-1:0] i_mem_rdata;
    logic                  i_mem_err;

    modport master (
        output o_mem_req,
        output o_mem_addr,
        input  i_mem_gnt,
        input  i_mem_rvalid,
        input  i_mem_rdata,
        input  i_mem_err
    );

    modport slave (
        input  o_mem_req,
        input  o_mem_addr,
        output i_mem_gnt,
        output i_mem_rvalid,
        output i_mem_rdata,
        output i_mem_err
    );

endinterface

// File: rtl/imem_fetch_fifo.sv
// Small circular instruction buffer; pointers wrap at DEPTH so non power-of-two
// depths work. Flush clears occupancy and overrides push/pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wr_ptr_inc;
    logic [PW-1:0]    w_rd_ptr_inc;

    assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;

    // Storage is reset so the head fields read zero out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= w_wr_ptr_inc;
            end
            if (i_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, responses
// buffered in fetch_fifo, redirect (flush) discards buffered and in-flight data.
module imem_fetch
    import imem_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_flush,
    imem_fetch_if.master          mem,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic                  o_err
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH + 1;

    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("imem_fetch: DEPTH must be in 2..8");
    end

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_flush_seen;
    logic                  w_flush_seen_nxt;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_count;
    logic [EW-1:0]         w_head;

    assign o_ready  = (r_state == ST_IDLE) && (w_count < CW'(DEPTH)) && !i_flush;
    assign w_accept = i_valid && o_ready;
    assign o_valid  = (w_count != '0);
    assign w_pop    = o_valid && i_ready;

    // A flush while the request is still waiting for grant must not be lost:
    // it is remembered so the granted response gets dropped.
    always_comb begin
        w_state_nxt      = r_state;
        w_flush_seen_nxt = r_flush_seen;
        w_push           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_flush_seen_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.i_mem_gnt) begin
                    w_state_nxt      = (i_flush || r_flush_seen) ? ST_DROP : ST_WAIT;
                    w_flush_seen_nxt = 1'b0;
                end else if (i_flush) begin
                    w_flush_seen_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_flush) begin
                    w_state_nxt = mem.i_mem_rvalid ? ST_IDLE : ST_DROP;
                end else if (mem.i_mem_rvalid) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (mem.i_mem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_flush_seen <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_seen <= w_flush_seen_nxt;
            if (w_accept) begin
                r_addr <= i_pc;
            end
        end
    end

    assign mem.o_mem_req  = (r_state == ST_REQ);
    assign mem.o_mem_addr = r_addr;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_push  (w_push),
        .i_data  ({r_addr, mem.i_mem_rdata, mem.i_mem_err}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign o_pc   = w_head[EW-1 -: ADDR_WIDTH];
    assign o_inst = w_head[DATA_WIDTH:1];
    assign o_err  = w_head[0];

endmodule

// File: doc/imem_fetch.md
IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the PC and memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter DEPTH, default 2, SHALL set the instruction buffer entries; the legal range SHALL be 2..8.
REQ-004 i_clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_valid  in  1  upstream PC valid; o_ready  out  1  this block accepts the PC.
REQ-007 i_pc  in  ADDR_WIDTH  PC to fetch.
REQ-008 i_flush  in  1  redirect: discard all buffered and in-flight fetches.
REQ-009 o_mem_req  out  1  read request; o_mem_addr  out  ADDR_WIDTH  read address; i_mem_gnt  in  1  request accepted.
REQ-010 i_mem_rvalid  in  1  response valid; i_mem_rdata  in  DATA_WIDTH  instruction; i_mem_err  in  1  access fault.
REQ-011 o_valid  out  1  instruction available; i_ready  in  1  downstream accepts it.
REQ-012 o_pc  out  ADDR_WIDTH, o_inst  out  DATA_WIDTH, o_err  out  1: head-entry fields.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT and DROP, with at most one memory transaction outstanding.
REQ-014 o_ready SHALL equal (state==IDLE && count<DEPTH && !i_flush).
REQ-015 In IDLE, on i_valid && o_ready, i_pc SHALL be latched into the address register and the FSM SHALL go to REQ.
REQ-016 In REQ, o_mem_req SHALL be 1, o_mem_addr SHALL equal the latched PC, and both SHALL stay stable until i_mem_gnt; in every other state o_mem_req SHALL be 0.
REQ-017 In REQ with i_mem_gnt, next state SHALL be WAIT, or DROP if i_flush is high or was seen since entering REQ.
REQ-018 In WAIT with i_mem_rvalid && !i_flush, {latched PC, i_mem_rdata, i_mem_err} SHALL be pushed to the buffer and the FSM SHALL go to IDLE.
REQ-019 In WAIT with i_flush, the FSM SHALL go to DROP, or directly to IDLE if i_mem_rvalid is high the same cycle (response discarded).
REQ-020 In DROP, i_mem_rvalid SHALL be discarded and the FSM SHALL go to IDLE; nothing SHALL be pushed.
REQ-021 i_mem_rvalid outside WAIT/DROP SHALL be ignored.
REQ-022 The buffer SHALL be a FIFO with circular read/write pointers wrapping at DEPTH and a count of 0..DEPTH.
REQ-023 o_valid SHALL equal (count!=0); o_pc/o_inst/o_err SHALL show the head entry and stay stable while o_valid && !i_ready.
REQ-024 Pop SHALL occur on o_valid && i_ready; simultaneous push and pop SHALL leave count unchanged.
REQ-025 Push never overflows: acceptance requires count<DEPTH and only one fetch is in flight.
REQ-026 i_flush SHALL clear count and pointers in its cycle; it SHALL override any same-cycle push or pop, and o_valid SHALL be 0 the next cycle.
REQ-027 Minimum latency: accept at cycle T, o_mem_req at T+1, gnt at T+1, rvalid at T+2, o_valid at T+3.
REQ-028 o_err SHALL be carried with its instruction and SHALL NOT change FSM behaviour.

Reset
REQ-029 While i_rst_n=0: state IDLE, count 0, pointers 0, address register 0, flush-seen flag 0.
REQ-030 Output values during and after reset: o_valid=0, o_mem_req=0, o_mem_addr=0, o_pc=0, o_inst=0, o_err=0.
REQ-031 Reset during REQ/WAIT SHALL abandon the transaction; a late i_mem_rvalid after reset SHALL be ignored (REQ-021).

Structure
REQ-032 The shared core package SHALL hold the FSM state enum (2-bit) and the ADDR_WIDTH/DATA_WIDTH defaults.
REQ-033 The buffer SHALL be one sub-module, fetch_fifo, parameterised by entry width and DEPTH, with a flush input.

Verification
REQ-034 Back-to-back: PCs 0x8000_0000 and 0x8000_0004, gnt immediate, rvalid next cycle, i_ready=1 -> two outputs in order, first o_valid at T+3, o_pc/o_inst match.
REQ-035 Backpressure: i_ready=0, three PCs offered -> two accepted, o_ready=0 with count=2, head held stable; then i_ready=1 -> drains in order, third PC accepted.
REQ-036 Gnt stall: i_mem_gnt low for 3 cycles -> o_mem_req/o_mem_addr=0x8000_0000 held unchanged all 3 cycles.
REQ-037 Flush in WAIT: i_flush one cycle before rvalid with rdata 0xDEAD_BEEF -> no push, o_valid=0; next PC 0x8000_0100 fetched normally.
REQ-038 Flush with full buffer plus same-cycle pop and rvalid -> count=0, state IDLE, o_valid=0 next cycle.
REQ-039 Fault: i_mem_err=1 with rvalid for PC 0x8000_0008 -> o_err=1 with o_pc=0x8000_0008; next fetch has o_err=0.
